// File: rtl/flash_arb.sv
// flash_arb: wakes the SPI flash out of power-down, then shares the
// spixpress Wishbone read port round-robin between two requesters.
module flash_arb #(
   parameter logic [23:0] FLASH_BASE = 24'h040000,
   parameter int          WAKE_WAIT  = 100
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ready,
   input  logic        r0_req,
   input  logic        r1_req,
   input  logic [21:0] r0_addr,
   input  logic [21:0] r1_addr,
   output logic        r0_ack,
   output logic        r1_ack,
   output logic [31:0] r0_data,
   output logic [31:0] r1_data,
   output logic        fl_cyc,
   output logic        fl_stb,
   output logic [21:0] fl_addr,
   output logic [3:0]  fl_sel,
   input  logic        fl_stall,
   input  logic        fl_ack,
   input  logic [31:0] fl_data,
   output logic        cfg_cyc,
   output logic        cfg_stb,
   output logic        cfg_we,
   output logic [31:0] cfg_data,
   input  logic        cfg_stall,
   input  logic        cfg_ack
);

   localparam int CW = $clog2(WAKE_WAIT + 1);

   typedef enum logic [2:0] {
      WAKE_CMD,
      WAKE_REL,
      WAKE_DLY,
      IDLE,
      REQ,
      WAIT_ACK,
      DONE
   } state_t;

   state_t      r_state;
   logic [CW-1:0] r_cnt;
   logic        r_last;
   logic        r_gnt;
   logic        r_ready;
   logic        r_r0_ack;
   logic        r_r1_ack;
   logic [31:0] r_r0_data;
   logic [31:0] r_r1_data;
   logic        r_fl_cyc;
   logic        r_fl_stb;
   logic [21:0] r_fl_addr;
   logic [3:0]  r_fl_sel;
   logic        r_cfg_cyc;
   logic        r_cfg_stb;
   logic        r_cfg_we;
   logic [31:0] r_cfg_data;

   logic [21:0] w_base;
   logic        w_pick1;
   logic [21:0] w_gaddr;

   assign w_base  = FLASH_BASE[23:2];
   // requester 1 wins when alone, or on a tie when 0 was served last
   assign w_pick1 = r1_req & (~r0_req | ~r_last);
   assign w_gaddr = (w_pick1 ? r1_addr : r0_addr) + w_base;

   // wake sequence, arbitration and Wishbone handshakes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= WAKE_CMD;
         r_cnt      <= '0;
         r_last     <= 1'b1;
         r_gnt      <= 1'b0;
         r_ready    <= 1'b0;
         r_r0_ack   <= 1'b0;
         r_r1_ack   <= 1'b0;
         r_r0_data  <= '0;
         r_r1_data  <= '0;
         r_fl_cyc   <= 1'b0;
         r_fl_stb   <= 1'b0;
         r_fl_addr  <= '0;
         r_fl_sel   <= '0;
         r_cfg_cyc  <= 1'b0;
         r_cfg_stb  <= 1'b0;
         r_cfg_we   <= 1'b0;
         r_cfg_data <= '0;
      end else begin
         unique case (r_state)
            WAKE_CMD, WAKE_REL: begin
               if (!r_cfg_cyc) begin
                  r_cfg_cyc  <= 1'b1;
                  r_cfg_stb  <= 1'b1;
                  r_cfg_we   <= 1'b1;
                  r_cfg_data <= (r_state == WAKE_CMD) ?
                                32'h0000_01AB : 32'h0;
               end else if (r_cfg_stb) begin
                  if (!cfg_stall) begin
                     r_cfg_stb <= 1'b0;
                     r_cfg_we  <= 1'b0;
                  end
               end else if (cfg_ack) begin
                  r_cfg_cyc <= 1'b0;
                  if (r_state == WAKE_CMD) begin
                     r_state <= WAKE_REL;
                  end else begin
                     r_state <= WAKE_DLY;
                     r_cnt   <= CW'(WAKE_WAIT - 1);
                  end
               end
            end
            WAKE_DLY: begin
               if (r_cnt == '0) begin
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            IDLE: begin
               if (r0_req | r1_req) begin
                  r_gnt     <= w_pick1;
                  r_last    <= w_pick1;
                  r_fl_addr <= w_gaddr;
                  r_fl_cyc  <= 1'b1;
                  r_fl_stb  <= 1'b1;
                  r_fl_sel  <= 4'hF;
                  r_state   <= REQ;
               end
            end
            REQ: begin
               if (!fl_stall) begin
                  r_fl_stb <= 1'b0;
                  r_state  <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (fl_ack) begin
                  if (r_gnt) begin
                     r_r1_data <= fl_data;
                     r_r1_ack  <= 1'b1;
                  end else begin
                     r_r0_data <= fl_data;
                     r_r0_ack  <= 1'b1;
                  end
                  r_fl_cyc <= 1'b0;
                  r_fl_sel <= 4'h0;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_r0_ack <= 1'b0;
               r_r1_ack <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= WAKE_CMD;
         endcase
      end
   end

   assign ready    = r_ready;
   assign r0_ack   = r_r0_ack;
   assign r1_ack   = r_r1_ack;
   assign r0_data  = r_r0_data;
   assign r1_data  = r_r1_data;
   assign fl_cyc   = r_fl_cyc;
   assign fl_stb   = r_fl_stb;
   assign fl_addr  = r_fl_addr;
   assign fl_sel   = r_fl_sel;
   assign cfg_cyc  = r_cfg_cyc;
   assign cfg_stb  = r_cfg_stb;
   assign cfg_we   = r_cfg_we;
   assign cfg_data = r_cfg_data;

endmodule

// File: tb/tb_flash_arb.sv
// tb_flash_arb: directed stimulus with queued expectations, checked by
// a monitor against flash and config-port bus models.
module tb_flash_arb;

   localparam int W = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ready;
   logic        r0_req = 1'b0, r1_req = 1'b0;
   logic [21:0] r0_addr = '0, r1_addr = '0;
   logic        r0_ack, r1_ack;
   logic [31:0] r0_data, r1_data;
   logic        fl_cyc, fl_stb;
   logic [21:0] fl_addr;
   logic [3:0]  fl_sel;
   logic        fl_stall = 1'b0, fl_ack = 1'b0;
   logic [31:0] fl_data = '0;
   logic        cfg_cyc, cfg_stb, cfg_we;
   logic [31:0] cfg_data;
   logic        cfg_stall = 1'b0, cfg_ack = 1'b0;

   int n_pass = 0;
   int n_chk  = 0;

   typedef struct {
      logic        id;
      logic [31:0] data;
   } rd_t;
   typedef struct {
      logic [21:0] addr;
      int          stb;
   } fl_t;

   rd_t         rd_q[$];
   fl_t         fl_q[$];
   logic [31:0] cfg_q[$];

   int stall_left = 0;
   bit hold_ack   = 0;
   bit pend       = 0;
   bit cpend      = 0;

   flash_arb #(.FLASH_BASE(24'h040000), .WAKE_WAIT(W)) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .r0_req(r0_req), .r1_req(r1_req),
      .r0_addr(r0_addr), .r1_addr(r1_addr),
      .r0_ack(r0_ack), .r1_ack(r1_ack),
      .r0_data(r0_data), .r1_data(r1_data),
      .fl_cyc(fl_cyc), .fl_stb(fl_stb), .fl_addr(fl_addr),
      .fl_sel(fl_sel), .fl_stall(fl_stall), .fl_ack(fl_ack),
      .fl_data(fl_data),
      .cfg_cyc(cfg_cyc), .cfg_stb(cfg_stb), .cfg_we(cfg_we),
      .cfg_data(cfg_data), .cfg_stall(cfg_stall), .cfg_ack(cfg_ack)
   );

   always #5 clk = ~clk;

   function automatic void check(string nm, logic [31:0] act,
                                 logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endfunction

   function automatic logic [31:0] fmem(logic [21:0] a);
      if (a == 22'h010010) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // flash and config-port slave models, driven on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         fl_ack   = 1'b0;
         fl_stall = 1'b0;
         cfg_ack  = 1'b0;
         pend     = 0;
         cpend    = 0;
      end else begin
         fl_ack = 1'b0;
         if (pend && !hold_ack) begin
            fl_ack  = 1'b1;
            fl_data = fmem(fl_addr);
            pend    = 0;
         end
         fl_stall = fl_stb && (stall_left > 0);
         if (fl_stall) stall_left--;
         if (fl_stb && !fl_stall) pend = 1;
         cfg_ack = cpend;
         cpend   = cfg_stb && !cfg_stall;
      end
   end

   int  cfg_acks = 0;
   int  dly      = -1;
   int  stbcnt   = 0;
   bit  rdy_prev = 0;
   bit  seen_cyc = 0;
   bit  prev0    = 0;
   bit  prev1    = 0;

   // monitor: pops queued expectations as the DUT presents outputs
   always @(negedge clk) begin
      rd_t         re;
      fl_t         fe;
      logic [31:0] ce;
      #1;
      if (!rst) begin
         cfg_acks = 0;
         dly      = -1;
         stbcnt   = 0;
         rdy_prev = 0;
         seen_cyc = 0;
         prev0    = 0;
         prev1    = 0;
      end else begin
         if (fl_stb) stbcnt++;
         if (fl_cyc && !ready) seen_cyc = 1;
         if (fl_stb && !fl_stall) begin
            if (fl_q.size() == 0) begin
               check("unexpected fl strobe", 32'(fl_stb), 0);
            end else begin
               fe = fl_q.pop_front();
               check("fl_addr", 32'(fl_addr), 32'(fe.addr));
               check("fl_sel", 32'(fl_sel), 32'hF);
               check("fl_stb cycles", stbcnt, fe.stb);
            end
            stbcnt = 0;
         end
         if (cfg_stb && !cfg_stall) begin
            if (cfg_q.size() == 0) begin
               check("unexpected cfg write", 32'(cfg_stb), 0);
            end else begin
               ce = cfg_q.pop_front();
               check("cfg_data", cfg_data, ce);
               check("cfg_we", 32'(cfg_we), 1);
            end
         end
         if (cfg_ack) begin
            cfg_acks++;
            if (cfg_acks == 2) dly = 0;
         end else if (dly >= 0) begin
            dly++;
         end
         if (ready && !rdy_prev) begin
            check("ready delay", dly, W + 1);
            check("cfg write count", cfg_acks, 2);
            check("fl_cyc before ready", 32'(seen_cyc), 0);
         end
         rdy_prev = ready;
         if (prev0) check("r0_ack pulse", 32'(r0_ack), 0);
         if (prev1) check("r1_ack pulse", 32'(r1_ack), 0);
         if (r0_ack || r1_ack) begin
            if (rd_q.size() == 0) begin
               check("unexpected ack", {r1_ack, r0_ack}, 0);
            end else begin
               re = rd_q.pop_front();
               check("ack both", 32'(r0_ack & r1_ack), 0);
               check("grant id", 32'(r1_ack), 32'(re.id));
               check("read data", r1_ack ? r1_data : r0_data, re.data);
            end
         end
         prev0 = r0_ack;
         prev1 = r1_ack;
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (ready) break;
      end
      check("ready timeout", 32'(ready), 1);
   endtask

   task automatic wait_ack(input bit id);
      bit got = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (id ? r1_ack : r0_ack) begin
            got = 1;
            break;
         end
      end
      check("ack timeout", 32'(got), 1);
      if (id) r1_req = 1'b0;
      else r0_req = 1'b0;
   endtask

   task automatic push_rd(input logic id, input logic [21:0] fa,
                          input logic [31:0] d, input int s);
      fl_q.push_back('{addr: fa, stb: s});
      rd_q.push_back('{id: id, data: d});
   endtask

   initial begin
      int acks;
      bit got;
      cfg_q.push_back(32'h0000_01AB);
      cfg_q.push_back(32'h0);
      repeat (2) @(negedge clk);
      check("reset ready", 32'(ready), 0);
      check("reset fl_cyc", 32'(fl_cyc), 0);
      check("reset cfg_cyc", 32'(cfg_cyc), 0);
      check("reset r0_data", r0_data, 0);
      rst = 1'b1;

      // early request during wake, also the single read
      push_rd(1'b0, 22'h010010, 32'hDEADBEEF, 1);
      repeat (5) @(negedge clk);
      r0_addr = 22'h000010;
      r0_req  = 1'b1;
      wait_ready();
      @(negedge clk);
      check("early req served", 32'(fl_stb), 1);
      wait_ack(1'b0);
      check("r1_data untouched", r1_data, 0);

      // stall and address wrap on requester 1
      stall_left = 3;
      r1_addr = 22'h3FFFFF;
      push_rd(1'b1, 22'h00FFFF, 32'hFFFF0000, 4);
      r1_req = 1'b1;
      wait_ack(1'b1);
      check("r0_data held", r0_data, 32'hDEADBEEF);

      // tie: both held for four reads
      r0_addr = 22'h000100;
      r1_addr = 22'h000200;
      for (int k = 0; k < 2; k++) begin
         push_rd(1'b0, 22'h010100, 32'h0100FEFF, 1);
         push_rd(1'b1, 22'h010200, 32'h0200FDFF, 1);
      end
      r0_req = 1'b1;
      r1_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 500 && acks < 4; i++) begin
         @(negedge clk);
         if (r0_ack || r1_ack) acks++;
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      check("tie ack count", acks, 4);

      // reset while waiting for the flash ack
      hold_ack = 1;
      fl_q.push_back('{addr: 22'h010100, stb: 1});
      r0_req = 1'b1;
      got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fl_cyc && !fl_stb) begin
            got = 1;
            break;
         end
      end
      check("reached wait_ack", 32'(got), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst fl_cyc", 32'(fl_cyc), 0);
      check("rst ready", 32'(ready), 0);
      r0_req = 1'b0;
      hold_ack = 0;
      cfg_q.push_back(32'h0000_01AB);
      cfg_q.push_back(32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_ready();
      push_rd(1'b1, 22'h010200, 32'h0200FDFF, 1);
      r1_req = 1'b1;
      wait_ack(1'b1);

      repeat (5) @(negedge clk);
      check("rd_q drained", rd_q.size(), 0);
      check("fl_q drained", fl_q.size(), 0);
      check("cfg_q drained", cfg_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
